l2_prefetch_fill: RTL and testbench

Fill engine directly upstream of the L2 prefetch buffer: owns the buffer's write port (WRA/WRD/WR/WRM/CLR). On a CPU read miss it fetches a burst-aligned line from memory and writes it into the buffer; on a hit to the last word of a line it prefetches the next line. It also forwards CPU write snoops so buffered data stays coherent, and sweeps the buffer invalid on FLUSH.

---
 rtl/l2_prefetch_fill_pkg.sv | 29 ++
 rtl/l2_prefetch_fill.sv | 223 ++++++++++++++++++++++
 tb/tb_l2_prefetch_fill.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/l2_prefetch_fill_pkg.sv
// rtl/l2_prefetch_fill_pkg.sv - shared types and defaults for the L2 prefetch fill engine
//
// Purpose: state encoding, default geometry and the beat-counter width helper
//          used by l2_prefetch_fill.
// Ports:   none (package).
package l2_prefetch_fill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SWEEP = 3'd4
  } state_t;

  localparam int BURST_DEF   = 4;
  localparam int ENTRIES_DEF = 128;
  localparam int ADDR_W      = 27;
  localparam int DATA_W      = 32;
  localparam int MASK_W      = 4;

  // Beat counter width: log2(BURST), never narrower than one bit.
  function automatic int cnt_width(input int burst);
    return (burst <= 2) ? 1 : $clog2(burst);
  endfunction

  localparam int CNT_W_DEF = cnt_width(BURST_DEF);

endpackage

// File: rtl/l2_prefetch_fill.sv
// rtl/l2_prefetch_fill.sv - line fill / next-line prefetch engine owning the L2 prefetch buffer write port
//
// Purpose: fetches a BURST-aligned line on a CPU read miss (or the next line on
//          a hit to the last word of a line), writes the beats into the buffer,
//          forwards CPU write snoops with priority, and sweeps the buffer
//          invalid on FLUSH.
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   CPUREQ, CPUA, HIT      CPU read observation and buffer hit indication
//   SNPWR, SNPA/SNPD/SNPM  CPU write snoop (address, data, byte mask)
//   FLUSH                  invalidate the whole buffer
//   MEMREQ, MEMA, MEMACK   burst read request handshake
//   MEMDV, MEMD            returning burst beats (no back-pressure)
//   WRA/WRD/WR/WRM/CLR     buffer write port (all registered)
//   BUSY                   high whenever the engine is not idle
import l2_prefetch_fill_pkg::*;

module l2_prefetch_fill #(
  parameter int BURST   = BURST_DEF,
  parameter int ENTRIES = ENTRIES_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPUREQ,
  input  logic [ADDR_W-1:0] CPUA,
  input  logic              HIT,
  input  logic              SNPWR,
  input  logic [ADDR_W-1:0] SNPA,
  input  logic [DATA_W-1:0] SNPD,
  input  logic [MASK_W-1:0] SNPM,
  input  logic              FLUSH,
  output logic              MEMREQ,
  output logic [ADDR_W-1:0] MEMA,
  input  logic              MEMACK,
  input  logic              MEMDV,
  input  logic [DATA_W-1:0] MEMD,
  output logic [ADDR_W-1:0] WRA,
  output logic [DATA_W-1:0] WRD,
  output logic              WR,
  output logic [MASK_W-1:0] WRM,
  output logic              CLR,
  output logic              BUSY
);

  localparam int CW = cnt_width(BURST);
  // Sweep index runs one past the last entry so BUSY stays high while the
  // final clear write is visible.
  localparam int IW = $clog2(ENTRIES + 1);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BURST - 1);

  state_t            state;
  logic [CW-1:0]     rx_cnt;     // index of the next beat to arrive
  logic              rx_all;     // every beat of the line has arrived
  logic [BURST-1:0]  stale;      // words overwritten by snoops while in flight
  logic              hold_v;
  logic [DATA_W-1:0] hold_d;
  logic [CW-1:0]     hold_i;
  logic              fill_done;  // last beat retired; leave FILL next cycle
  logic              flush_pend; // FLUSH seen while waiting for MEMACK
  logic [IW-1:0]     sweep_idx;

  logic              snp_act;
  logic              snp_in_line;
  logic [CW-1:0]     snp_off;
  logic [ADDR_W-1:0] cpu_base;
  logic              cpu_last;
  logic              beat_last;
  logic              fw_take;
  logic [CW-1:0]     fw_idx;
  logic [DATA_W-1:0] fw_data;
  logic              park;

  always_comb begin
    snp_act     = SNPWR && (state != ST_SWEEP);
    snp_in_line = ((SNPA & ~LOW_MASK) == MEMA);
    snp_off     = SNPA[CW-1:0];
    cpu_base    = CPUA & ~LOW_MASK;
    cpu_last    = &CPUA[CW-1:0];
    beat_last   = (rx_cnt == CW'(BURST - 1));
    // Write-port priority during FILL: snoop, then parked beat, then new beat.
    fw_take     = !snp_act && (hold_v || MEMDV);
    fw_idx      = hold_v ? hold_i : rx_cnt;
    fw_data     = hold_v ? hold_d : MEMD;
    // A beat that cannot use the port this cycle is parked. Memory beat
    // spacing is assumed to keep the single hold entry from overflowing.
    park        = MEMDV && (snp_act || hold_v);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      MEMREQ     <= 1'b0;
      MEMA       <= '0;
      BUSY       <= 1'b0;
      WR         <= 1'b0;
      WRA        <= '0;
      WRD        <= '0;
      WRM        <= '0;
      CLR        <= 1'b0;
      rx_cnt     <= '0;
      rx_all     <= 1'b0;
      stale      <= '0;
      hold_v     <= 1'b0;
      hold_d     <= '0;
      hold_i     <= '0;
      fill_done  <= 1'b0;
      flush_pend <= 1'b0;
      sweep_idx  <= '0;
    end else begin
      WR  <= 1'b0;
      CLR <= 1'b0;
      WRA <= '0;
      WRD <= '0;
      WRM <= '0;

      if (snp_act) begin
        WR  <= 1'b1;
        WRA <= SNPA;
        WRD <= SNPD;
        WRM <= SNPM;
      end

      if ((state == ST_REQ || state == ST_FILL) && snp_act && snp_in_line)
        stale[snp_off] <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (FLUSH) begin
            state     <= ST_SWEEP;
            sweep_idx <= '0;
            BUSY      <= 1'b1;
          end else if (CPUREQ && (!HIT || cpu_last)) begin
            // Miss fetches this line; hit on the last word prefetches the next.
            state      <= ST_REQ;
            MEMREQ     <= 1'b1;
            MEMA       <= HIT ? (cpu_base + ADDR_W'(BURST)) : cpu_base;
            BUSY       <= 1'b1;
            stale      <= '0;
            flush_pend <= 1'b0;
          end
        end

        ST_REQ: begin
          if (FLUSH)
            flush_pend <= 1'b1;
          if (MEMACK) begin
            MEMREQ    <= 1'b0;
            rx_cnt    <= '0;
            rx_all    <= 1'b0;
            hold_v    <= 1'b0;
            fill_done <= 1'b0;
            state     <= (flush_pend || FLUSH) ? ST_DRAIN : ST_FILL;
          end
        end

        ST_FILL: begin
          if (FLUSH) begin
            // Buffered beats are pointless once the sweep clears everything.
            hold_v    <= 1'b0;
            sweep_idx <= '0;
            if (MEMDV)
              rx_cnt <= rx_cnt + CW'(1);
            if (rx_all || (MEMDV && beat_last))
              state <= ST_SWEEP;
            else
              state <= ST_DRAIN;
          end else if (fill_done) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end else begin
            if (MEMDV) begin
              rx_cnt <= rx_cnt + CW'(1);
              if (beat_last)
                rx_all <= 1'b1;
            end
            if (fw_take) begin
              if (!stale[fw_idx]) begin
                WR  <= 1'b1;
                WRA <= MEMA + ADDR_W'(fw_idx);
                WRD <= fw_data;
                WRM <= 4'hF;
              end
              if (fw_idx == CW'(BURST - 1))
                fill_done <= 1'b1;
            end
            hold_v <= park;
            if (park) begin
              hold_d <= MEMD;
              hold_i <= rx_cnt;
            end
          end
        end

        ST_DRAIN: begin
          if (MEMDV) begin
            rx_cnt <= rx_cnt + CW'(1);
            if (beat_last) begin
              state     <= ST_SWEEP;
              sweep_idx <= '0;
            end
          end
        end

        ST_SWEEP: begin
          if (sweep_idx == IW'(ENTRIES)) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end else begin
            WR        <= 1'b1;
            CLR       <= 1'b1;
            WRM       <= 4'hF;
            WRD       <= '0;
            WRA       <= ADDR_W'(sweep_idx);
            sweep_idx <= sweep_idx + IW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_prefetch_fill.sv
// tb/tb_l2_prefetch_fill.sv - directed self-checking bench for l2_prefetch_fill
module tb_l2_prefetch_fill;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CPUREQ = 1'b0;
  logic [26:0] CPUA = '0;
  logic        HIT = 1'b0;
  logic        SNPWR = 1'b0;
  logic [26:0] SNPA = '0;
  logic [31:0] SNPD = '0;
  logic [3:0]  SNPM = '0;
  logic        FLUSH = 1'b0;
  logic        MEMREQ;
  logic [26:0] MEMA;
  logic        MEMACK = 1'b0;
  logic        MEMDV = 1'b0;
  logic [31:0] MEMD = '0;
  logic [26:0] WRA;
  logic [31:0] WRD;
  logic        WR;
  logic [3:0]  WRM;
  logic        CLR;
  logic        BUSY;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  l2_prefetch_fill dut (
    .CLK(CLK), .RST(RST), .CPUREQ(CPUREQ), .CPUA(CPUA), .HIT(HIT),
    .SNPWR(SNPWR), .SNPA(SNPA), .SNPD(SNPD), .SNPM(SNPM), .FLUSH(FLUSH),
    .MEMREQ(MEMREQ), .MEMA(MEMA), .MEMACK(MEMACK), .MEMDV(MEMDV), .MEMD(MEMD),
    .WRA(WRA), .WRD(WRD), .WR(WR), .WRM(WRM), .CLR(CLR), .BUSY(BUSY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] dat(input logic [26:0] base, input int i);
    return {base[23:0], 8'(i)};
  endfunction

  task automatic start_req(input logic [26:0] a, input logic hit, input logic [26:0] exp_base);
    CPUREQ = 1'b1; CPUA = a; HIT = hit;
    step();
    CPUREQ = 1'b0; HIT = 1'b0;
    chk("memreq_up", MEMREQ, 1);
    chk("mema", MEMA, exp_base);
    chk("busy_req", BUSY, 1);
    MEMACK = 1'b1;
    step();
    MEMACK = 1'b0;
    chk("memreq_down", MEMREQ, 0);
  endtask

  task automatic send_beats(input logic [26:0] base, input int first, input int last, input logic exp_wr);
    for (int i = first; i <= last; i++) begin
      MEMDV = 1'b1; MEMD = dat(base, i);
      step();
      MEMDV = 1'b0;
      chk($sformatf("beat%0d_wr", i), WR, exp_wr);
      if (exp_wr) begin
        chk($sformatf("beat%0d_wra", i), WRA, base + 27'(i));
        chk($sformatf("beat%0d_wrd", i), WRD, dat(base, i));
        chk($sformatf("beat%0d_wrm", i), WRM, 4'hF);
      end
    end
  endtask

  task automatic finish_fill();
    chk("busy_after_last_wr", BUSY, 1);
    step();
    chk("busy_low", BUSY, 0);
  endtask

  initial begin
    int ok;
    int n;

    // Reset state
    step(); step();
    chk("rst_memreq", MEMREQ, 0);
    chk("rst_wr", WR, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_mema", MEMA, 0);
    chk("rst_clr", CLR, 0);
    RST = 1'b0;
    step();

    // Miss at 0x123 fetches line 0x120
    start_req(27'h0000123, 1'b0, 27'h0000120);
    send_beats(27'h0000120, 0, 3, 1'b1);
    finish_fill();

    // Hit on last word prefetches next line
    start_req(27'h0000127, 1'b1, 27'h0000128);
    send_beats(27'h0000128, 0, 3, 1'b1);
    finish_fill();

    // Hit not on last word is ignored
    CPUREQ = 1'b1; CPUA = 27'h0000125; HIT = 1'b1;
    step();
    CPUREQ = 1'b0; HIT = 1'b0;
    chk("hit_mid_memreq", MEMREQ, 0);
    chk("hit_mid_busy", BUSY, 0);

    // Snoop into in-flight line suppresses the matching beat
    start_req(27'h0000121, 1'b0, 27'h0000120);
    send_beats(27'h0000120, 0, 1, 1'b1);
    SNPWR = 1'b1; SNPA = 27'h0000122; SNPD = 32'hAAAA_5555; SNPM = 4'b0011;
    step();
    SNPWR = 1'b0;
    chk("snp_wr", WR, 1);
    chk("snp_wra", WRA, 27'h0000122);
    chk("snp_wrd", WRD, 32'hAAAA_5555);
    chk("snp_wrm", WRM, 4'b0011);
    send_beats(27'h0000120, 2, 2, 1'b0);
    send_beats(27'h0000120, 3, 3, 1'b1);
    finish_fill();

    // Beat and snoop in the same cycle: snoop first, beat parked one cycle
    start_req(27'h0000200, 1'b0, 27'h0000200);
    MEMDV = 1'b1; MEMD = dat(27'h0000200, 0);
    SNPWR = 1'b1; SNPA = 27'h0000050; SNPD = 32'h1234_5678; SNPM = 4'hF;
    step();
    MEMDV = 1'b0; SNPWR = 1'b0;
    chk("coll_snp_wr", WR, 1);
    chk("coll_snp_wra", WRA, 27'h0000050);
    chk("coll_snp_wrd", WRD, 32'h1234_5678);
    step();
    chk("coll_beat_wr", WR, 1);
    chk("coll_beat_wra", WRA, 27'h0000200);
    chk("coll_beat_wrd", WRD, dat(27'h0000200, 0));
    send_beats(27'h0000200, 1, 3, 1'b1);
    finish_fill();

    // FLUSH mid-fill: remaining beats dropped, full sweep follows
    start_req(27'h0000301, 1'b0, 27'h0000300);
    send_beats(27'h0000300, 0, 1, 1'b1);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("flush_wr", WR, 0);
    chk("flush_busy", BUSY, 1);
    send_beats(27'h0000300, 2, 3, 1'b0);
    ok = 1;
    for (int i = 0; i < 128; i++) begin
      step();
      if (!(WR === 1'b1 && CLR === 1'b1 && WRA === 27'(i) && WRM === 4'hF && WRD === 32'h0))
        ok = 0;
      if (i == 0) chk("sweep_first_wra", WRA, 0);
      if (i == 127) begin
        chk("sweep_last_wra", WRA, 127);
        chk("sweep_last_busy", BUSY, 1);
      end
    end
    chk("sweep_all_entries", ok, 1);
    step();
    chk("sweep_done_busy", BUSY, 0);
    chk("sweep_done_wr", WR, 0);

    // Reset during FILL
    start_req(27'h0000400, 1'b0, 27'h0000400);
    send_beats(27'h0000400, 0, 0, 1'b1);
    RST = 1'b1; MEMDV = 1'b1; MEMD = dat(27'h0000400, 1);
    step();
    RST = 1'b0;
    chk("rst_fill_memreq", MEMREQ, 0);
    chk("rst_fill_wr", WR, 0);
    chk("rst_fill_busy", BUSY, 0);
    chk("rst_fill_wra", WRA, 0);
    chk("rst_fill_wrd", WRD, 0);
    chk("rst_fill_mema", MEMA, 0);
    MEMD = dat(27'h0000400, 2);
    step();
    MEMDV = 1'b0;
    chk("late_beat_wr", WR, 0);
    chk("late_beat_busy", BUSY, 0);

    // FLUSH and snoop together in IDLE
    FLUSH = 1'b1; SNPWR = 1'b1; SNPA = 27'h0000010; SNPD = 32'h55; SNPM = 4'h1;
    step();
    FLUSH = 1'b0; SNPWR = 1'b0;
    chk("fs_snp_wr", WR, 1);
    chk("fs_snp_clr", CLR, 0);
    chk("fs_snp_wra", WRA, 27'h0000010);
    step();
    chk("fs_sweep_clr", CLR, 1);
    chk("fs_sweep_wra", WRA, 0);
    n = 0;
    while (BUSY === 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("fs_sweep_len", n, 128);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
